nanosoc_apb_msgfifo: RTL and testbench

- APB3 completer peripheral for one SYSIO expansion slot (exp12..exp15 PSEL group).
- Gives the CPU a bidirectional word mailbox: APB writes fill a TX FIFO that drains to a valid/ready output stream; a valid/ready input stream fills an RX FIFO that APB reads drain.
- Provides programmable wait-state or error behaviour on full/empty FIFOs, a bounded-wait timeout, and a level interrupt into SYS_APB_IRQ.

---
 rtl/nanosoc_apb_msgfifo_pkg.sv | 29 ++
 rtl/nanosoc_sync_fifo.sv | 55 +++++
 rtl/nanosoc_apb_msgfifo.sv | 162 ++++++++++++++++
 tb/tb_nanosoc_apb_msgfifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nanosoc_apb_msgfifo_pkg.sv
// Shared register map, bit positions and sizing helper for the APB message FIFO.
package nanosoc_apb_msgfifo_pkg;

  // Word offsets within the 16-byte register window (PADDR[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STICKY = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 12;

  localparam int CTRL_TX_IRQ_EN = 0;
  localparam int CTRL_RX_IRQ_EN = 1;
  localparam int CTRL_BLOCK_EN  = 2;

  localparam int STK_TX_OVERFLOW  = 0;
  localparam int STK_RX_UNDERFLOW = 1;
  localparam int STK_TIMEOUT      = 2;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nanosoc_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head reads 0 when empty.
module nanosoc_sync_fifo
  import nanosoc_apb_msgfifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int CNT_W = count_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nanosoc_apb_msgfifo.sv
// APB3 word mailbox: DATA writes feed the TX stream, RX stream feeds DATA reads.
// state    | meaning
// ST_IDLE  | no access stalled last cycle; wait count treated as zero
// ST_STALL | access is being held with PREADY=0; wait_cnt counts stalled cycles
module nanosoc_apb_msgfifo
  import nanosoc_apb_msgfifo_pkg::*;
#(
  parameter int APB_ADDR_W   = 12,
  parameter int APB_DATA_W   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  TX_VALID,
  output logic [APB_DATA_W-1:0] TX_DATA,
  input  logic                  TX_READY,
  input  logic                  RX_VALID,
  input  logic [APB_DATA_W-1:0] RX_DATA,
  output logic                  RX_READY,
  output logic                  IRQ
);

  localparam int CNT_W = count_w(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  state_t                state, state_nxt;
  logic [7:0]            wait_cnt, wait_cnt_nxt, cur_wait;
  logic [2:0]            ctrl, sticky, sticky_set;
  logic                  irq_q;
  logic [APB_ADDR_W-3:0] word_addr;
  logic [1:0]            reg_sel;
  logic                  addr_ok, is_data, access, complete, bad, err_cond;
  logic                  tx_ovf, rx_udf, stall_req, timeout_hit;
  logic                  tx_push, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic [CNT_W-1:0]      tx_count, rx_count;
  logic [APB_DATA_W-1:0] rx_head, status, rdata;
  logic                  unused_paddr;

  assign unused_paddr = &{1'b0, PADDR[1:0]};

  assign word_addr = PADDR[APB_ADDR_W-1:2];
  assign reg_sel   = word_addr[1:0];
  assign addr_ok   = (word_addr[APB_ADDR_W-3:2] == '0);
  assign is_data   = addr_ok & (reg_sel == REG_DATA);
  assign access    = PSEL & PENABLE;
  assign bad       = ~addr_ok | (PWRITE & (reg_sel == REG_STATUS));

  // Full/empty come straight from registered counts, so a same-cycle stream pop never bypasses
  assign tx_ovf    = PWRITE & is_data & tx_full & ~ctrl[CTRL_BLOCK_EN];
  assign rx_udf    = ~PWRITE & is_data & rx_empty & ~ctrl[CTRL_BLOCK_EN];
  assign stall_req = access & is_data & ctrl[CTRL_BLOCK_EN] &
                     (PWRITE ? tx_full : rx_empty);

  assign cur_wait    = (state == ST_STALL) ? wait_cnt : 8'd0;
  assign timeout_hit = stall_req & (cur_wait == 8'(WAIT_TIMEOUT));

  assign PREADY   = ~stall_req | timeout_hit;
  assign complete = access & PREADY;
  assign err_cond = bad | tx_ovf | rx_udf | timeout_hit;
  assign PSLVERR  = complete & err_cond;

  assign tx_push = complete & ~err_cond & PWRITE & is_data;
  assign rx_pop  = complete & ~err_cond & ~PWRITE & is_data;

  always_comb begin
    state_nxt    = ST_IDLE;
    wait_cnt_nxt = 8'd0;
    if (stall_req && !timeout_hit) begin
      state_nxt    = ST_STALL;
      wait_cnt_nxt = cur_wait + 8'd1;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_TX_FULL]          = tx_full;
    status[ST_TX_EMPTY]         = tx_empty;
    status[ST_RX_FULL]          = rx_full;
    status[ST_RX_EMPTY]         = rx_empty;
    status[ST_TX_CNT +: 4]      = 4'(tx_count);
    status[ST_RX_CNT +: 4]      = 4'(rx_count);
  end

  always_comb begin
    rdata = '0;
    if (complete && !err_cond && !PWRITE) begin
      case (reg_sel)
        REG_DATA:   rdata = rx_head;
        REG_STATUS: rdata = status;
        REG_CTRL:   rdata = APB_DATA_W'(ctrl);
        default:    rdata = APB_DATA_W'(sticky);
      endcase
    end
  end
  assign PRDATA = rdata;

  always_comb begin
    sticky_set                   = '0;
    sticky_set[STK_TX_OVERFLOW]  = complete & tx_ovf;
    sticky_set[STK_RX_UNDERFLOW] = complete & rx_udf;
    sticky_set[STK_TIMEOUT]      = timeout_hit;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      ctrl     <= '0;
      sticky   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (complete && !err_cond && PWRITE && reg_sel == REG_CTRL)
        ctrl <= PWDATA[2:0];
      if (complete && !err_cond && PWRITE && reg_sel == REG_STICKY)
        sticky <= (sticky & ~PWDATA[2:0]) | sticky_set;
      else
        sticky <= sticky | sticky_set;
      irq_q <= (ctrl[CTRL_TX_IRQ_EN] & tx_empty) |
               (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) | (|sticky);
    end
  end
  assign IRQ = irq_q;

  nanosoc_sync_fifo #(.DATA_W(APB_DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push      (tx_push),
    .push_data (PWDATA),
    .pop       (TX_VALID & TX_READY),
    .head      (TX_DATA),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );
  assign TX_VALID = ~tx_empty;

  nanosoc_sync_fifo #(.DATA_W(APB_DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push      (RX_VALID & RX_READY),
    .push_data (RX_DATA),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );
  assign RX_READY = ~rx_full;

endmodule

// File: tb/tb_nanosoc_apb_msgfifo.sv
// Directed bench for the APB message FIFO: register map, stream order, stalls, timeout, IRQ.
module tb_nanosoc_apb_msgfifo;

  logic        clk, rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [31:0] tx_data, rx_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        er;
  int          ws;
  int          stalls;
  logic [31:0] exp_tx [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  nanosoc_apb_msgfifo dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PADDR    (paddr),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr),
    .TX_VALID (tx_valid),
    .TX_DATA  (tx_data),
    .TX_READY (tx_ready),
    .RX_VALID (rx_valid),
    .RX_DATA  (rx_data),
    .RX_READY (rx_ready),
    .IRQ      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!pready && waits < 300) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("pready_bound", 32'(pready), 32'd1);
    rdata = prdata;
    err   = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'd1);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    apb(1'b0, 12'h004, 0, rd, er, ws);
    check("status_rst", rd, 32'h0000_000A);
    check("status_rst_waits", ws, 0);
    check("status_rst_err", 32'(er), 32'd0);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    check("idle_tx_valid", 32'(tx_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      apb(1'b1, 12'h000, exp_tx[i], rd, er, ws);
      check("tx_fill_err", 32'(er), 32'd0);
    end
    apb(1'b0, 12'h004, 0, rd, er, ws);
    check("status_tx_full", rd, 32'h0000_0409);
    check("tx_head", tx_data, 32'h11);

    apb(1'b1, 12'h000, 32'h55, rd, er, ws);
    check("ovf_err", 32'(er), 32'd1);
    check("ovf_waits", ws, 0);
    apb(1'b0, 12'h004, 0, rd, er, ws);
    check("ovf_no_push", rd, 32'h0000_0409);
    apb(1'b0, 12'h00C, 0, rd, er, ws);
    check("sticky_ovf", rd, 32'h1);
    check("irq_sticky", 32'(irq), 32'd1);
    apb(1'b1, 12'h00C, 32'h1, rd, er, ws);
    apb(1'b0, 12'h00C, 0, rd, er, ws);
    check("sticky_clr", rd, 32'h0);
    check("irq_clr", 32'(irq), 32'd0);

    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("tx_stream_valid", 32'(tx_valid), 32'd1);
      check("tx_stream_data", tx_data, exp_tx[i]);
      @(negedge clk);
      #1;
    end
    check("tx_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    apb(1'b1, 12'h008, 32'h4, rd, er, ws);
    apb(1'b0, 12'h008, 0, rd, er, ws);
    check("ctrl_rd", rd, 32'h4);

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    #1;
    check("setup_prdata", prdata, 32'h0);
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      penable = 1'b1;
      if (c == 2) begin rx_valid = 1'b1; rx_data = 32'hCAFE; end
      #1;
      if (!pready) stalls++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check("blk_stalls", stalls, 3);
    check("blk_pready", 32'(pready), 32'd1);
    check("blk_prdata", prdata, 32'hCAFE);
    check("blk_err", 32'(pslverr), 32'd0);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;

    apb(1'b0, 12'h000, 0, rd, er, ws);
    check("tmo_waits", ws, 16);
    check("tmo_err", 32'(er), 32'd1);
    apb(1'b0, 12'h00C, 0, rd, er, ws);
    check("tmo_sticky", rd, 32'h4);
    apb(1'b0, 12'h004, 0, rd, er, ws);
    check("tmo_status", rd, 32'h0000_000A);
    check("tmo_irq", 32'(irq), 32'd1);
    apb(1'b1, 12'h00C, 32'h7, rd, er, ws);

    apb(1'b0, 12'h010, 0, rd, er, ws);
    check("bad_addr_err", 32'(er), 32'd1);
    check("bad_addr_waits", ws, 0);
    check("bad_addr_data", rd, 32'h0);
    apb(1'b1, 12'h004, 32'hFFFF, rd, er, ws);
    check("wr_status_err", 32'(er), 32'd1);
    check("wr_status_waits", ws, 0);
    apb(1'b0, 12'h008, 0, rd, er, ws);
    check("ctrl_kept", rd, 32'h4);
    apb(1'b0, 12'h00C, 0, rd, er, ws);
    check("sticky_kept", rd, 32'h0);

    apb(1'b1, 12'h008, 32'h5, rd, er, ws);
    tick(1);
    check("irq_tx_empty", 32'(irq), 32'd1);
    apb(1'b1, 12'h008, 32'h2, rd, er, ws);
    tick(1);
    check("irq_rx_idle", 32'(irq), 32'd0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 32'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    tick(1);
    check("irq_rx_data", 32'(irq), 32'd1);
    apb(1'b0, 12'h000, 0, rd, er, ws);
    check("rx_pop_data", rd, 32'h55);
    check("rx_pop_err", 32'(er), 32'd0);
    tick(1);
    check("irq_rx_drained", 32'(irq), 32'd0);
    apb(1'b1, 12'h008, 32'h0, rd, er, ws);
    apb(1'b0, 12'h000, 0, rd, er, ws);
    check("udf_err", 32'(er), 32'd1);
    check("udf_data", rd, 32'h0);
    apb(1'b0, 12'h00C, 0, rd, er, ws);
    check("udf_sticky", rd, 32'h2);
    apb(1'b1, 12'h00C, 32'h2, rd, er, ws);

    apb(1'b1, 12'h008, 32'h4, rd, er, ws);
    apb(1'b1, 12'h000, 32'h99, rd, er, ws);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1;
    check("pre_rst_stall", 32'(pready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pready", 32'(pready), 32'd1);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    apb(1'b0, 12'h004, 0, rd, er, ws);
    check("post_rst_status", rd, 32'h0000_000A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
